// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer around a single one-bit FullAdder cell, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output (ovf).

module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_ext;

    FullAdder u_fa (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Bits gathered so far plus this cycle's sum bit; on the last bit this is the full result.
    assign res_ext = {fa_sum, res_q};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sh_a_d  = op_a;
                    sh_b_d  = op_b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                res_d   = res_ext[WIDTH-1:1];
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_ext;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on the final bit.
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against an arithmetic reference model.
// Build with SERIAL_ADDER_OVF_EN defined to also check the ovf output.

module tb_serial_adder_ctrl;

    localparam int W = 8;
    localparam int TIMEOUT = 40;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample/drive point: 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge (the start edge E0), then scramble the operand inputs.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        step();
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Waits for done (edges counted inclusive of E0) and checks latency, busy length and result.
    task automatic wait_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input int edges0, input int busy0,
                                  input bit expect_idle);
        int          edges;
        int          busy_cnt;
        logic [W:0]  full;
        int          s_sum;
        logic        exp_ovf;
        edges    = edges0;
        busy_cnt = busy0;
        full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s_sum    = $signed(a) + $signed(b) + int'(c);
        exp_ovf  = (s_sum > 127) || (s_sum < -128);
        while (done !== 1'b1 && edges < TIMEOUT) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            edges++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done not seen after %0d edges", name, edges);
            return;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_with_done: busy=%b required 0", name, busy);
        end
        checks++;
        if (edges != W + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", name, edges, W + 1);
        end
        checks++;
        if (busy_cnt != W) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, W);
        end
        checks++;
        if (sum !== full[W-1:0]) begin
            errors++;
            $display("FAIL %s sum: got %h required %h (a=%h b=%h cin=%b)", name, sum, full[W-1:0], a, b, c);
        end
        checks++;
        if (cout !== full[W]) begin
            errors++;
            $display("FAIL %s cout: got %b required %b", name, cout, full[W]);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf: got %b required %b", name, ovf, exp_ovf);
        end
`endif
        if (expect_idle) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse: done=%b busy=%b required 0/0", name, done, busy);
            end
            checks++;
            if (sum !== full[W-1:0] || cout !== full[W]) begin
                errors++;
                $display("FAIL %s hold: sum=%h cout=%b required %h/%b", name, sum, cout, full[W-1:0], full[W]);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b sum=%h cout=%b required all 0", name, busy, done, sum, cout);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s ovf: got %b required 0", name, ovf);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        #2;
        check_outputs_zero("reset_no_clock");
        #10;
        rst_n = 1'b1;
        step();
        check_outputs_zero("reset_released_idle");
    endtask

    task automatic test_directed();
        launch(8'h35, 8'h4A, 1'b0);
        wait_and_check("add_35_4a", 8'h35, 8'h4A, 1'b0, 1, 0, 1'b1);
        launch(8'hFF, 8'h01, 1'b0);
        wait_and_check("carry_ff_01", 8'hFF, 8'h01, 1'b0, 1, 0, 1'b1);
        launch(8'hFF, 8'hFF, 1'b1);
        wait_and_check("carry_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1, 0, 1'b1);
        launch(8'h00, 8'h00, 1'b1);
        wait_and_check("cin_only", 8'h00, 8'h00, 1'b1, 1, 0, 1'b1);
        launch(8'h7F, 8'h01, 1'b0);
        wait_and_check("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1, 0, 1'b1);
        launch(8'h80, 8'hFF, 1'b0);
        wait_and_check("ovf_80_ff", 8'h80, 8'hFF, 1'b0, 1, 0, 1'b1);
        launch(8'h05, 8'h03, 1'b0);
        wait_and_check("no_ovf_05_03", 8'h05, 8'h03, 1'b0, 1, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            launch(a, b, c);
            wait_and_check($sformatf("random_%0d", i), a, b, c, 1, 0, 1'b1);
        end
    endtask

    task automatic test_start_ignored();
        int busy0;
        busy0 = 0;
        launch(8'h10, 8'h20, 1'b0);
        start = 1'b1;
        op_a  = 8'h55;
        op_b  = 8'h55;
        cin   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1) busy0++;
            step();
        end
        start = 1'b0;
        wait_and_check("start_in_run_ignored", 8'h10, 8'h20, 1'b0, 5, busy0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom);
        b = W'($urandom);
        launch(a, b, 1'b0);
        wait_and_check("b2b_first", a, b, 1'b0, 1, 0, 1'b0);
        launch(8'h01, 8'h02, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%b done=%b required 1/0", busy, done);
        end
        wait_and_check("b2b_second", 8'h01, 8'h02, 1'b0, 1, 0, 1'b1);
    endtask

    task automatic test_abort();
        launch(8'h35, 8'h4A, 1'b0);
        wait_and_check("pre_abort", 8'h35, 8'h4A, 1'b0, 1, 0, 1'b1);
        launch(8'hFF, 8'hFF, 1'b1);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort_immediate");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done cycle %0d: done=%b busy=%b required 0/0", i, done, busy);
            end
        end
        launch(8'h0F, 8'h01, 1'b0);
        wait_and_check("after_abort", 8'h0F, 8'h01, 1'b0, 1, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder built around a single instance of the team's one-bit FullAdder (ports a, b, cin, sum, cout). The controller latches two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock through the shared full adder, LSB first. It registers the carry between cycles, assembles the result in a shift register, and signals completion with a done pulse. It is the sequencer that lets the lab datapath do N-bit addition with one adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk; accepted only in IDLE or DONE
op_a  input  WIDTH  operand A, latched on accepted start
op_b  input  WIDTH  operand B, latched on accepted start
cin  input  1  carry-in, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result; held from done until next accepted start completes
cout  output  1  registered final carry-out; held like sum

Behaviour:
- Reset: one clock; asynchronous, active-low. While rst_n=0: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift regs/carry/counter=0. Takes effect immediately, no clock needed. Release is synchronous to next clk edge.
- States: IDLE, RUN, DONE (2-bit encoded).
  - IDLE: start=1 -> load sh_a<=op_a, sh_b<=op_b, carry<=cin, cnt<=0; go to RUN.
  - RUN: full adder inputs a=sh_a[0], b=sh_b[0], cin=carry. Each edge: sh_a, sh_b shift right by 1; result shift reg takes FA sum into MSB and shifts right; carry<=FA cout; cnt<=cnt+1. When cnt==WIDTH-1 on this edge: sum<=completed result, cout<=FA cout, done<=1, go to DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> reload as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- busy=1 exactly in RUN; done=1 exactly in DONE; both registered, never high together.
- Latency: start sampled at edge E0. Bits processed at edges E1..E_WIDTH. done high in the cycle after E_WIDTH. Start-to-done is WIDTH+1 edges; throughput is one add per WIDTH+1 cycles with back-to-back starts.
- start while in RUN is ignored: no queuing, operands not relatched.
- Op inputs are sampled only on an accepted start and may change freely afterwards.
- cnt width is clog2(WIDTH). It is not compared past WIDTH-1, so it cannot wrap.
- sum/cout outputs change only on the edge entering DONE; the intermediate shift register is internal.
- Result equals (op_a + op_b + cin) mod 2^WIDTH; cout is bit WIDTH of that sum.
- Reset mid-RUN aborts the operation: outputs go to 0 and no done pulse occurs.

Optional Feature:
SERIAL_ADDER_OVF_EN:
- Defined: adds output port ovf (1 bit) carrying the signed two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB. It is captured alongside cout on entry to DONE, held like sum, and reset to 0.
- Undefined: no ovf port and no related logic.

Test Plan:
1. Reset: hold rst_n=0 mid-cycle -> busy=0, done=0, sum=8'h00, cout=0 without a clock edge.
2. WIDTH=8, op_a=8'h35, op_b=8'h4A, cin=0 -> done pulses 9 edges after start edge; sum=8'h7F, cout=0; busy high 8 cycles.
3. Carries: FF+01 cin=0 -> sum=8'h00, cout=1; FF+FF cin=1 -> sum=8'hFF, cout=1; 00+00 cin=1 -> sum=8'h01, cout=0.
4. start with 10+20, then start=1 with 55+55 during RUN -> second ignored; result sum=8'h30 only.
5. Back-to-back: start held during DONE with 01+02 -> first result visible on done; second result sum=8'h03 after another 9 edges, no IDLE cycle between.
6. Abort: rst_n pulsed low at RUN bit 3 -> all outputs 0, no done; new start 0F+01 -> sum=8'h10. With SERIAL_ADDER_OVF_EN: 7F+01 -> ovf=1; 80+FF -> ovf=1, cout=1; 05+03 -> ovf=0.
